barrel_shift_pipe: RTL and testbench
====================================

Name: barrel_shift_pipe

Overview:
- Parametrised, two-stage pipelined multi-mode barrel shifter. Successor to the single-mode registered shift-left block.
- Supports logical left/right, arithmetic right and rotate left/right on an N-bit operand, with per-transaction mode and amount.
- Uses valid/ready handshakes on both sides and sustains one result per cycle. Sits between register-file read data and the ALU result mux.

Parameters:
- N, 8, operand width. Must be a power of two, >= 2.
- AW, $clog2(N), shift-amount width. Local parameter, derived from N, not overridable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  global enable; 0 freezes the whole pipeline.
- in_valid  input  1  d/amt/mode are valid.
- in_ready  output  1  block can accept an input this cycle.
- d  input  N  operand.
- amt  input  AW  shift amount, 0..N-1.
- mode  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others reserved.
- out_valid  output  1  out/zero are valid.
- out_ready  input  1  consumer accepts the result.
- out  output  N  shifted result.
- zero  output  1  out == 0.

Behaviour:
- Reset (rst=0, asynchronous): v1=v2=0, out=0, zero=0, all data/mode/amt registers cleared.
  - in_ready=1 from the first edge after release, provided en=1.
  - Any in-flight transactions are discarded.
- Stage 1 (S1): on input accept, shift d by {amt[AW-1:1],1'b0} (the even part) using mode. Register partial result, amt[0], mode and v1.
- Stage 2 (S2): shift the S1 result by amt[0] using the same mode. Register out, zero and v2.
  - Same-type shifts compose, so the result equals a single shift by amt.
- Mode semantics:
  - SLL, SRL: zero fill.
  - SRA: fill with the original d[N-1].
  - ROL, ROR: circular.
  - Reserved modes: pass d through unchanged.
  - amt=0 yields d in every mode.
- Handshake:
  - S2 accepts when ready2 = !v2 || out_ready.
  - S1 accepts when ready1 = !v1 || ready2.
  - in_ready = en && ready1.
  - Input transfer = in_valid && in_ready. Output transfer = out_valid && out_ready && en.
- Latency: exactly 2 cycles from input transfer to out_valid=1 when no stall. Throughput: 1 per cycle.
- Stall: while out_valid=1 and out_ready=0, out and zero hold stable. S1 still fills if empty; after that in_ready=0. No loss, no duplication, order preserved.
- Simultaneous pop and push on a full pipeline: both transfers occur in the same cycle and the pipeline stays full.
- en=0: no register changes, in_ready=0, out_valid and out held, and out_ready is ignored.
- in_valid with in_ready=0: the input is not captured. The producer must hold it.
- out_valid is a pure register bit (v2). There is no combinational path from in_valid to out_valid.

Decomposition:
- Package shift_pkg:
  - typedef enum logic [2:0] shift_mode_e {SLL, SRL, SRA, ROL, ROR}.
  - Constant for the reserved-mode pass-through.
- Sub-module shift_unit, combinational, parameter N. Inputs: data, amount, mode, fill bit.
  - Instantiated once per stage; S1 uses an even amount, S2 uses 0 or 1.
  - fill bit = d[N-1] for SRA, captured in S1 and carried into S2.

Test Plan (N=8):
- Reset:
  - Hold rst=0 while two transactions are in flight -> out_valid=0, out=8'h00 immediately (asynchronous).
  - After release with en=1 -> in_ready=1; the dropped results never appear.
- SLL: d=8'hB3, amt=3, mode=000 accepted at cycle t -> out_valid=1 at t+2, out=8'h98, zero=0.
- Right shifts and rotates, with d=8'h90, amt=5:
  - SRA -> 8'hFC.
  - SRL -> 8'h04.
  - ROR, d=8'h81, amt=1 -> 8'hC0.
  - ROL, d=8'h81, amt=7 -> 8'hC0.
  - Back-to-back issue of all four -> four consecutive out_valid cycles, in order.
- Backpressure:
  - Stream 5 vectors and hold out_ready=0 from the first out_valid -> in_ready=0 after 2 accepted; out stays at the first result.
  - Raise out_ready -> all 5 results appear in order, with no gaps while in_valid remains asserted.
- Zero flag and reserved mode:
  - SLL, d=8'h10, amt=4 -> out=8'h00, zero=1.
  - mode=3'b111, d=8'h5A, amt=6 -> out=8'h5A, zero=0.
  - SRL, d=8'h01, amt=1 -> zero=1.
- en freeze:
  - Drop en for 3 cycles mid-stream with out_ready=1 -> in_ready=0, out/out_valid unchanged, no transaction lost or repeated on resume.
  - Close with a 2000-vector random run checked against a reference model.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: shared mode encoding for the pipelined barrel shifter.
//   shift_mode_e : operation select carried on the 3-bit mode port
//   MODE_MAX     : highest defined mode; anything above passes the operand through
package shift_pkg;
    typedef enum logic [2:0] {
        SLL = 3'b000,
        SRL = 3'b001,
        SRA = 3'b010,
        ROL = 3'b011,
        ROR = 3'b100
    } shift_mode_e;
    localparam logic [2:0] MODE_MAX = 3'(ROR);
endpackage

// File: rtl/shift_unit.sv
// shift_unit: combinational N-bit shifter/rotator for a single stage.
//   data_i : operand
//   amt_i  : shift amount
//   mode_i : shift_mode_e encoding; reserved codes return data_i
//   fill_i : bit shifted in from the top for SRA (sign of the original operand)
//   res_o  : result
module shift_unit
    import shift_pkg::*;
#(
    parameter int N = 8,
    localparam int AW = $clog2(N)
) (
    input  logic [N-1:0]  data_i,
    input  logic [AW-1:0] amt_i,
    input  logic [2:0]    mode_i,
    input  logic          fill_i,
    output logic [N-1:0]  res_o
);
    logic [2*N-1:0] lsh, rsh, fsh;
    logic [N-1:0]   shifted;
    always_comb begin
        lsh = {data_i, data_i} << amt_i;
        rsh = {data_i, data_i} >> amt_i;
        // fill comes from the original operand, so a second stage still sign-extends correctly
        fsh = {{N{fill_i}}, data_i} >> amt_i;
        case (mode_i)
            SLL:     shifted = data_i << amt_i;
            SRL:     shifted = data_i >> amt_i;
            SRA:     shifted = fsh[N-1:0];
            ROL:     shifted = lsh[2*N-1:N];
            ROR:     shifted = rsh[N-1:0];
            default: shifted = data_i;
        endcase
        res_o = (mode_i > MODE_MAX) ? data_i : shifted;
    end
endmodule

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: two-stage pipelined multi-mode barrel shifter with valid/ready on both sides.
//   clk, rst        : clock, asynchronous active-low reset
//   en              : global enable, 0 freezes every register
//   in_valid/ready  : input handshake for d, amt, mode
//   out_valid/ready : output handshake for out, zero
//   out, zero       : shifted result and its all-zero flag
// Stage 1 shifts by the even part of amt, stage 2 by amt[0]; same-mode shifts compose.
module barrel_shift_pipe
    import shift_pkg::*;
#(
    parameter int N = 8,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  d,
    input  logic [AW-1:0] amt,
    input  logic [2:0]    mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out,
    output logic          zero
);
    logic          v1_q, v2_q, a0_q, fill1_q, zero_q;
    logic [N-1:0]  p1_q, p1_d, out_q, out_d;
    logic [2:0]    mode1_q;
    logic [AW-1:0] s1_amt;
    logic          ready1, ready2;

    // masking bit 0 also covers N=2, where amt has no upper bits
    assign s1_amt = amt & ~AW'(1);
    assign ready2 = !v2_q || out_ready;
    assign ready1 = !v1_q || ready2;
    assign in_ready = en && ready1;
    assign out_valid = v2_q;
    assign out = out_q;
    assign zero = zero_q;

    shift_unit #(.N(N)) u_s1 (
        .data_i(d),
        .amt_i (s1_amt),
        .mode_i(mode),
        .fill_i(d[N-1]),
        .res_o (p1_d)
    );

    shift_unit #(.N(N)) u_s2 (
        .data_i(p1_q),
        .amt_i (AW'(a0_q)),
        .mode_i(mode1_q),
        .fill_i(fill1_q),
        .res_o (out_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            p1_q    <= '0;
            a0_q    <= 1'b0;
            mode1_q <= '0;
            fill1_q <= 1'b0;
            out_q   <= '0;
            zero_q  <= 1'b0;
        end else if (en) begin
            if (ready1) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    p1_q    <= p1_d;
                    a0_q    <= amt[0];
                    mode1_q <= mode;
                    fill1_q <= d[N-1];
                end
            end
            if (ready2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    out_q  <= out_d;
                    zero_q <= (out_d == '0);
                end
            end
        end
    end
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb_barrel_shift_pipe: directed and random checks of barrel_shift_pipe with N=8.
module tb_barrel_shift_pipe;
    import shift_pkg::*;

    logic       clk = 1'b0, rst = 1'b0, en = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic       in_ready, out_valid, zero;
    logic [7:0] d = '0, out;
    logic [2:0] amt = '0, mode = '0;
    int         n_chk = 0, n_pass = 0;
    logic [7:0] sb[$];

    logic [7:0] b_d [4] = '{8'h90, 8'h90, 8'h81, 8'h81};
    logic [2:0] b_a [4] = '{3'd5, 3'd5, 3'd1, 3'd7};
    logic [2:0] b_m [4] = '{SRA, SRL, ROR, ROL};
    logic [7:0] b_e [4] = '{8'hFC, 8'h04, 8'hC0, 8'hC0};

    logic [7:0] p_d [5] = '{8'h01, 8'h80, 8'h12, 8'h40, 8'h03};
    logic [2:0] p_a [5] = '{3'd1, 3'd7, 3'd4, 3'd2, 3'd1};
    logic [2:0] p_m [5] = '{SLL, SRL, ROL, SRA, ROR};
    logic [7:0] p_e [5] = '{8'h02, 8'h01, 8'h21, 8'h10, 8'h81};

    always #5 clk = ~clk;

    barrel_shift_pipe #(.N(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .d        (d),
        .amt      (amt),
        .mode     (mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .zero     (zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] ref_shift(input logic [7:0] x, input int a, input logic [2:0] m);
        logic [7:0] r;
        for (int i = 0; i < 8; i++)
            case (m)
                3'd0:    r[i] = (i >= a) ? x[i-a] : 1'b0;
                3'd1:    r[i] = (i + a < 8) ? x[i+a] : 1'b0;
                3'd2:    r[i] = (i + a < 8) ? x[i+a] : x[7];
                3'd3:    r[i] = x[(i - a + 8) % 8];
                3'd4:    r[i] = x[(i + a) % 8];
                default: r[i] = x[i];
            endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready && en) begin
                if (sb.size() == 0) check("sb_underflow", out_valid, 0);
                else begin
                    logic [7:0] e;
                    e = sb.pop_front();
                    check("sb_out", out, e);
                    check("sb_zero", zero, e == 8'h00);
                end
            end
            if (in_valid && in_ready) sb.push_back(ref_shift(d, int'(amt), mode));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] pd, input logic [2:0] pa, input logic [2:0] pm, input bit rnd);
        bit acc;
        int n;
        n = 0;
        d = pd;
        amt = pa;
        mode = pm;
        in_valid = 1'b1;
        do begin
            if (rnd) begin
                out_ready = $urandom_range(0, 3) != 0;
                en = $urandom_range(0, 7) != 0;
            end
            #1;
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) check("push_timeout", acc, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        en = 1'b1;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic run1(input string tag, input logic [7:0] pd, input logic [2:0] pa, input logic [2:0] pm,
                        input logic [7:0] eo, input logic ez);
        d = pd;
        amt = pa;
        mode = pm;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_v_t1"}, out_valid, 0);
        step();
        check({tag, "_v_t2"}, out_valid, 1);
        check({tag, "_out"}, out, eo);
        check({tag, "_zero"}, zero, ez);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        bit sv;
        logic [7:0] so;
        int idx;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_out", out, 8'h00);
        step();
        step();
        rst = 1'b1;
        check("rst_release_ready", in_ready, 1);
        push(8'h11, 3'd1, SLL, 0);
        push(8'h22, 3'd2, SLL, 0);
        in_valid = 1'b0;
        check("inflight_valid", out_valid, 1);
        #1 rst = 1'b0;
        #1;
        check("async_valid", out_valid, 0);
        check("async_out", out, 8'h00);
        check("async_zero", zero, 0);
        sb.delete();
        step();
        rst = 1'b1;
        check("release_ready", in_ready, 1);
        repeat (4) begin
            step();
            check("no_ghost", out_valid, 0);
        end

        run1("sll", 8'hB3, 3'd3, SLL, 8'h98, 0);
        run1("sll_zero", 8'h10, 3'd4, SLL, 8'h00, 1);
        run1("rsv", 8'h5A, 3'd6, 3'b111, 8'h5A, 0);
        run1("srl_zero", 8'h01, 3'd1, SRL, 8'h00, 1);
        run1("ror_amt0", 8'hA5, 3'd0, ROR, 8'hA5, 0);
        run1("sra_amt0", 8'h80, 3'd0, SRA, 8'h80, 0);

        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                d = b_d[c];
                amt = b_a[c];
                mode = b_m[c];
                in_valid = 1'b1;
            end else in_valid = 1'b0;
            step();
            if (c >= 1 && c <= 4) begin
                check("b2b_valid", out_valid, 1);
                check("b2b_out", out, b_e[c-1]);
            end else if (c == 5) check("b2b_end", out_valid, 0);
        end

        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 5) begin
                d = p_d[idx];
                amt = p_a[idx];
                mode = p_m[idx];
                in_valid = 1'b1;
            end
            #1;
            acc = in_ready && in_valid;
            step();
            if (acc) idx++;
            if (c >= 1) check("bp_hold", out, p_e[0]);
        end
        check("bp_accepted", idx, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            check("bp_stream_valid", out_valid, 1);
            check("bp_stream_out", out, p_e[j]);
            if (idx < 5) begin
                d = p_d[idx];
                amt = p_a[idx];
                mode = p_m[idx];
                in_valid = 1'b1;
            end else in_valid = 1'b0;
            #1;
            acc = in_ready && in_valid;
            step();
            if (acc) idx++;
        end
        check("bp_all_accepted", idx, 5);
        drain();

        push(8'hC3, 3'd2, ROL, 0);
        push(8'h96, 3'd3, SRA, 0);
        push(8'h7E, 3'd5, SRL, 0);
        d = 8'h3C;
        amt = 3'd6;
        mode = ROR;
        in_valid = 1'b1;
        en = 1'b0;
        sv = out_valid;
        so = out;
        check("frz_busy", sv, 1);
        repeat (3) begin
            #1;
            check("frz_ready", in_ready, 0);
            check("frz_valid", out_valid, sv);
            check("frz_out", out, so);
            step();
        end
        check("frz_out_after", out, so);
        en = 1'b1;
        push(8'h3C, 3'd6, ROR, 0);
        push(8'hE1, 3'd7, SLL, 0);
        drain();

        for (int i = 0; i < 2000; i++)
            push(8'($urandom), 3'($urandom), 3'($urandom_range(0, 7)), 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
